// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
//   Phase scheduler for a two-road intersection. The crossing is shared by the
//   main road (default owner), a side-road vehicle sensor and a pedestrian
//   button. An emergency preempt overrides all three. The scheduler sequences
//   green, yellow, all-red and walk phases and enforces minimum and maximum
//   green times.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   side_req     side-road vehicle sensor (level)
//   ped_req      pedestrian button (pulse of any length, latched)
//   emerg_req    emergency preempt (level), forces main-road green
//   light_main   main lamps {R,Y,G}
//   light_side   side lamps {R,Y,G}
//   ped_walk     walk signal, high only in the walk phase
//   ped_pending  latched pedestrian request not yet served
//   phase        current state code (debug)
module intersection_phase_scheduler #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 60,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALL_RED_T = 2,
  parameter int unsigned WALK_T    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg_req,
  output logic [2:0] light_main,
  output logic [2:0] light_side,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG = 3'd0,
    MY = 3'd1,
    AR = 3'd2,
    SG = 3'd3,
    SY = 3'd4,
    PW = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_e      state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        side_pend_q, side_pend_d;
  logic        ped_pend_q, ped_pend_d;
  logic        from_main_q, from_main_d;
  logic        from_pw_q, from_pw_d;

  logic        tick;
  logic        trans;
  logic [31:0] elapsed;

  assign tick    = (presc_q == TICK_DIV - 1);
  assign elapsed = tick_cnt_q + 32'd1;
  assign trans   = (state_d != state_q);

  // Next-state selection. Emergency is checked every cycle in SG and PW;
  // all other decisions are taken on a tick.
  always_comb begin
    state_d     = state_q;
    from_main_d = from_main_q;
    case (state_q)
      MG: begin
        if (!emerg_req && tick && elapsed >= MIN_GREEN &&
            (side_pend_q || ped_pend_q)) begin
          state_d     = MY;
          from_main_d = 1'b1;
        end
      end
      MY: if (tick && elapsed == YELLOW_T) state_d = AR;
      AR: begin
        if (tick && elapsed == ALL_RED_T) begin
          if (emerg_req)                       state_d = MG;
          else if (ped_pend_q && !from_pw_q)   state_d = PW;
          else if (from_main_q && side_pend_q) state_d = SG;
          else                                 state_d = MG;
        end
      end
      SG: begin
        if (emerg_req ||
            (tick && ((elapsed >= MIN_GREEN && !side_req) ||
                      elapsed == MAX_GREEN))) begin
          state_d     = SY;
          from_main_d = 1'b0;
        end
      end
      SY: if (tick && elapsed == YELLOW_T) state_d = AR;
      PW: if (emerg_req || (tick && elapsed == WALK_T)) state_d = AR;
      default: state_d = AR;
    endcase
  end

  // Both timers restart on any state change so each timed phase is exactly
  // N*TICK_DIV cycles long.
  always_comb begin
    presc_d    = presc_q + 32'd1;
    tick_cnt_d = tick_cnt_q;
    if (trans) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end else if (tick) begin
      presc_d    = '0;
      tick_cnt_d = tick_cnt_q + 32'd1;
    end
  end

  // Request latches: a request arriving on the entry edge survives the clear.
  always_comb begin
    side_pend_d = side_pend_q;
    ped_pend_d  = ped_pend_q;
    from_pw_d   = from_pw_q;
    if (trans && state_d == SG) side_pend_d = 1'b0;
    if (side_req)               side_pend_d = 1'b1;
    if (trans && state_d == PW) ped_pend_d  = 1'b0;
    if (ped_req)                ped_pend_d  = 1'b1;
    // Remembers whether the all-red being entered follows a walk, so a new
    // pedestrian request cannot immediately re-enter walk.
    if (trans)                  from_pw_d   = (state_q == PW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MG;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      from_main_q <= 1'b0;
      from_pw_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      from_main_q <= from_main_d;
      from_pw_q   <= from_pw_d;
    end
  end

  // Moore output decode; unknown codes show all red.
  always_comb begin
    light_main = LAMP_R;
    light_side = LAMP_R;
    case (state_q)
      MG: light_main = LAMP_G;
      MY: light_main = LAMP_Y;
      SG: light_side = LAMP_G;
      SY: light_side = LAMP_Y;
      default: ;
    endcase
  end

  assign ped_walk    = (state_q == PW);
  assign ped_pending = ped_pend_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler
//   Directed bench for intersection_phase_scheduler using small timing
//   parameters (TICK_DIV=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW_T=2,
//   ALL_RED_T=1, WALK_T=2). Cycle 0 is the cycle in which reset is released;
//   inputs are driven and outputs sampled on the falling clock edge.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg_req = 1'b0;
  logic [2:0] light_main;
  logic [2:0] light_side;
  logic       ped_walk;
  logic       ped_pending;
  logic [2:0] phase;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  intersection_phase_scheduler #(
    .TICK_DIV (4),
    .MIN_GREEN(3),
    .MAX_GREEN(6),
    .YELLOW_T (2),
    .ALL_RED_T(1),
    .WALK_T   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .emerg_req  (emerg_req),
    .light_main (light_main),
    .light_side (light_side),
    .ped_walk   (ped_walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected {main, side, walk} lamp pattern for a phase code.
  function automatic logic [6:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b0};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      3'd5:    return {3'b100, 3'b100, 1'b1};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic chk_ph(input string tag, input logic [2:0] ph);
    logic [6:0] e;
    e = lamps(ph);
    chk({tag, ".phase"}, {29'd0, phase}, {29'd0, ph});
    chk({tag, ".lamps"}, {25'd0, light_main, light_side, ped_walk}, {25'd0, e});
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    side_req = 1'b0;
    ped_req = 1'b0;
    emerg_req = 1'b0;
    #1;
    chk_ph({tag, ".rst"}, 3'd0);
    chk({tag, ".rst.pend"}, {31'd0, ped_pending}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // 1. Idle hold
    do_reset("idle");
    for (int i = 0; i < 10; i++) begin
      run_to(cyc + 20);
      chk_ph("idle", 3'd0);
    end

    // 2. Short side request
    do_reset("side");
    run_to(2);  side_req = 1'b1;
    run_to(3);  side_req = 1'b0;
    run_to(11); chk_ph("side.mg_end", 3'd0);
    run_to(12); chk_ph("side.my", 3'd1);
    run_to(19); chk_ph("side.my_end", 3'd1);
    run_to(20); chk_ph("side.ar", 3'd2);
    run_to(23); chk_ph("side.ar_end", 3'd2);
    run_to(24); chk_ph("side.sg", 3'd3);
    run_to(35); chk_ph("side.sg_end", 3'd3);
    run_to(36); chk_ph("side.sy", 3'd4);
    run_to(43); chk_ph("side.sy_end", 3'd4);
    run_to(44); chk_ph("side.ar2", 3'd2);
    run_to(47); chk_ph("side.ar2_end", 3'd2);
    run_to(48); chk_ph("side.mg", 3'd0);

    // 3. Side max green with side_req held
    do_reset("max");
    side_req = 1'b1;
    run_to(24); chk_ph("max.sg", 3'd3);
    run_to(47); chk_ph("max.sg_end", 3'd3);
    run_to(48); chk_ph("max.sy", 3'd4);
    run_to(50); side_req = 1'b0;
    run_to(56); chk_ph("max.ar", 3'd2);
    run_to(60); chk_ph("max.mg", 3'd0);
    run_to(71); chk_ph("max.mg_end", 3'd0);
    run_to(72); chk_ph("max.my", 3'd1);

    // 4. Pedestrian plus side
    do_reset("ped");
    run_to(1);  ped_req = 1'b1;
    run_to(2);  ped_req = 1'b0; side_req = 1'b1;
    chk("ped.pend_set", {31'd0, ped_pending}, 32'd1);
    run_to(3);  side_req = 1'b0;
    run_to(12); chk_ph("ped.my", 3'd1);
    run_to(23); chk_ph("ped.ar", 3'd2);
    chk("ped.pend_ar", {31'd0, ped_pending}, 32'd1);
    run_to(24); chk_ph("ped.pw", 3'd5);
    chk("ped.pend_clr", {31'd0, ped_pending}, 32'd0);
    run_to(31); chk_ph("ped.pw_end", 3'd5);
    run_to(32); chk_ph("ped.ar2", 3'd2);
    run_to(35); chk_ph("ped.ar2_end", 3'd2);
    run_to(36); chk_ph("ped.sg", 3'd3);

    // 5. Emergency in SG, ped request latched during preempt
    do_reset("emg");
    run_to(2);  side_req = 1'b1;
    run_to(3);  side_req = 1'b0;
    run_to(29); chk_ph("emg.sg", 3'd3);
    emerg_req = 1'b1;
    run_to(30); chk_ph("emg.sy", 3'd4);
    run_to(37); chk_ph("emg.sy_end", 3'd4);
    run_to(38); chk_ph("emg.ar", 3'd2);
    run_to(41); chk_ph("emg.ar_end", 3'd2);
    run_to(42); chk_ph("emg.mg", 3'd0);
    run_to(44); ped_req = 1'b1;
    run_to(45); ped_req = 1'b0;
    chk("emg.pend", {31'd0, ped_pending}, 32'd1);
    run_to(69); chk_ph("emg.hold", 3'd0);
    run_to(70); emerg_req = 1'b0;
    run_to(73); chk_ph("emg.mg_end", 3'd0);
    run_to(74); chk_ph("emg.my", 3'd1);
    run_to(82); chk_ph("emg.ar2", 3'd2);
    run_to(86); chk_ph("emg.pw", 3'd5);
    chk("emg.pend_clr", {31'd0, ped_pending}, 32'd0);
    run_to(94); chk_ph("emg.ar3", 3'd2);
    run_to(98); chk_ph("emg.mg2", 3'd0);

    // 6. Reset mid-MY
    do_reset("mrst");
    run_to(2);  side_req = 1'b1;
    run_to(3);  side_req = 1'b0;
    run_to(12); chk_ph("mrst.my", 3'd1);
    run_to(13); ped_req = 1'b1;
    run_to(14); ped_req = 1'b0;
    chk("mrst.pend", {31'd0, ped_pending}, 32'd1);
    reset = 1'b1;
    #1;
    chk_ph("mrst.async", 3'd0);
    chk("mrst.pend_clr", {31'd0, ped_pending}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      run_to(cyc + 15);
      chk_ph("mrst.hold", 3'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Phase scheduler for a two-road intersection that shares the crossing between three requesters: main road (default owner), side-road vehicle sensor and pedestrian button. An emergency preempt input overrides all three. It sequences green, yellow, all-red and walk phases, enforcing minimum and maximum green times. It drives the main and side R-Y-G lamp buses directly, replacing fixed-rotation light sequencing.

Parameters:
TICK_DIV, 50000000, clock cycles per timing tick (1 s at 50 MHz); must be >=1.
MIN_GREEN, 10, minimum green length in ticks, both roads.
MAX_GREEN, 60, maximum side green in ticks; must be >= MIN_GREEN.
YELLOW_T, 4, yellow length in ticks.
ALL_RED_T, 2, all-red clearance length in ticks.
WALK_T, 8, pedestrian walk length in ticks.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
side_req  in  1  side-road vehicle sensor, level.
ped_req  in  1  pedestrian button, any-length pulse.
emerg_req  in  1  emergency preempt, level; forces main-road green.
light_main  out  3  main lamps {R,Y,G}: 100 red, 010 yellow, 001 green.
light_side  out  3  side lamps, same encoding.
ped_walk  out  1  walk signal, high only in WALK.
ped_pending  out  1  latched pedestrian request not yet served.
phase  out  3  current state code, for debug.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (reset).
- States and phase codes: MG=0, MY=1, AR=2, SG=3, SY=4, PW=5. Moore outputs decode from the state register only.
  - MG: main 001, side 100.
  - MY: main 010, side 100.
  - AR and PW: both 100.
  - SG: main 100, side 001.
  - SY: main 100, side 010.
  - ped_walk=1 only in PW.
- Reset: state MG, prescaler=0, tick counter=0, side_pend=0, ped_pend=0, from_main=0. Outputs immediately read light_main=001, light_side=100, ped_walk=0, ped_pending=0, phase=0.
- Prescaler and tick counter:
  - Prescaler counts 0..TICK_DIV-1. tick=1 when prescaler==TICK_DIV-1.
  - tick_cnt increments on tick.
  - Both counters clear on every state transition, so a timed state lasts exactly N*TICK_DIV cycles.
- Request latches:
  - side_pend sets on any cycle with side_req=1; clears on entry to SG.
  - ped_pend sets on ped_req=1; clears on entry to PW. Set wins over clear in the same cycle.
  - ped_pending=ped_pend.
- Transitions (evaluated at tick, with elapsed = tick_cnt+1, unless noted):
  - MG -> MY: when emerg_req=0, elapsed>=MIN_GREEN and (side_pend or ped_pend). Exit also allowed at any later tick. With no requests, MG holds indefinitely. Sets from_main=1.
  - MY -> AR: at elapsed==YELLOW_T.
  - AR exit at elapsed==ALL_RED_T, first matching rule:
    - emerg_req -> MG.
    - ped_pend and previous state not PW -> PW.
    - from_main and side_pend -> SG.
    - else -> MG.
  - SG -> SY: when elapsed>=MIN_GREEN and side_req=0, or when elapsed==MAX_GREEN. Sets from_main=0.
  - SY -> AR: at elapsed==YELLOW_T.
  - PW -> AR: at elapsed==WALK_T.
- Emergency preempt, tested every cycle, not only at tick:
  - In SG: next edge goes to SY regardless of MIN_GREEN.
  - In PW: next edge goes to AR.
  - Yellow and all-red are never shortened.
  - MG holds while emerg_req=1.
  - Latched requests are retained and served after emerg_req falls.
- Conflicting greens are impossible by construction. Any illegal state code (6, 7) goes to AR on the next edge, with both roads red.
- Counters are 32 bits and never wrap under legal parameters.
- Reset mid-phase returns to MG immediately and discards pending requests.

Test Plan:
All scenarios use TICK_DIV=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW_T=2, ALL_RED_T=1, WALK_T=2.
1. Idle hold: release reset, no requests for 200 cycles -> phase=0, light_main=001, light_side=100 throughout.
2. Short side request: 1-cycle side_req pulse at cycle 2 -> MY at cycle 12, AR at 20, SG at 24, SY at 36, AR at 44, MG at 48.
3. Side max green: side_req held high -> SG lasts exactly 24 cycles; side_pend re-latches; MG then exits again at MIN_GREEN.
4. Pedestrian plus side: ped_req and side_req pulses both in MG -> sequence MG, MY, AR, PW (8 cycles, ped_walk=1, ped_pending drops on PW entry), AR, SG.
5. Emergency in SG: emerg_req asserted 5 cycles into SG -> SY on the next edge; after 8 cycles AR for 4; then MG, held while emerg_req=1. A ped_req latched during preempt is served after release.
6. Reset mid-MY: assert reset for 1 cycle -> outputs immediately 001/100, phase=0, ped_pending=0; no further transition without new requests.
